neighbor_fetch: RTL and testbench

NEIGHBOR_FETCH -- requirements
Module: neighbor_fetch

---
 rtl/neighbor_fetch_pkg.sv | 34 +++
 rtl/nf_fifo.sv | 50 +++++
 rtl/neighbor_fetch.sv | 134 +++++++++++++
 tb/tb_neighbor_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neighbor_fetch_pkg.sv
// Shared BFS types: vertex/round widths and the beat record carried through the
// neighbor-fetch output buffer.
package neighbor_fetch_pkg;

  localparam int ROUND_W = 2;
  localparam int VID_W   = 32;

  typedef logic [ROUND_W-1:0] round_t;
  typedef logic [VID_W-1:0]   vid_t;

  typedef struct packed {
    vid_t        neighbor;
    vid_t        sender;
    logic [31:0] num;
    round_t      round;
    logic        barrier;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_BARRIER = 2'd2;

  // A barrier beat carries only its round; every other field is zero.
  function automatic beat_t barrier_beat(input round_t r);
    beat_t b;
    b         = '0;
    b.round   = r;
    b.barrier = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/nf_fifo.sv
// Synchronous FIFO, power-of-two depth; occupancy exported so the producer can
// budget reads against free space.
module nf_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign w_push  = i_push & (r_cnt != (AW+1)'(DEPTH));
  assign w_pop   = i_pop & (r_cnt != '0);
  assign o_dout  = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/neighbor_fetch.sv
// Expands a vertex's adjacency list into one beat per neighbor read from edge
// memory, and turns round-barrier commands into a single barrier beat.
module neighbor_fetch
  import neighbor_fetch_pkg::*;
#(
  parameter int EDGE_ADDR_BITS = 16,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [31:0]               sender_in,
  input  logic [EDGE_ADDR_BITS-1:0] start_idx_in,
  input  logic [31:0]               num_neighbors_in,
  input  logic [1:0]                round_in,
  input  logic                      barrier_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic                      edge_rd_en,
  output logic [EDGE_ADDR_BITS-1:0] edge_rd_adr,
  input  logic [31:0]               edge_rd_dat,
  output logic [31:0]               neighbor_out,
  output logic [31:0]               sender_out,
  output logic [31:0]               num_neighbors_out,
  output logic [1:0]                round_out,
  output logic                      barrier_out,
  output logic                      valid_out,
  input  logic                      ready_in
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]                r_state;
  vid_t                      r_sender;
  logic [31:0]               r_num, r_count;
  round_t                    r_round;
  logic [EDGE_ADDR_BITS-1:0] r_addr;
  logic                      r_inflight;
  vid_t                      r_inf_sender;
  logic [31:0]               r_inf_num;
  round_t                    r_inf_round;

  logic             w_empty, w_valid, w_pop, w_push, w_rd, w_bar_push;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occ;
  beat_t            w_din, w_head;

  // A beat leaving this cycle frees its slot for a read issued this cycle,
  // which is what sustains one neighbor per cycle with a shallow buffer.
  assign w_valid    = ~sys_rst & ~w_empty;
  assign w_pop      = w_valid & ready_in;
  assign w_occ      = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
  assign w_rd       = ~sys_rst & (r_state == ST_FETCH) & (w_occ < (CNT_W+1)'(FIFO_DEPTH));
  assign w_bar_push = ~sys_rst & (r_state == ST_BARRIER) & w_empty & ~r_inflight;
  assign w_push     = (~sys_rst & r_inflight) | w_bar_push;

  always_comb begin
    w_din = barrier_beat(r_round);
    if (r_inflight) begin
      w_din.neighbor = edge_rd_dat;
      w_din.sender   = r_inf_sender;
      w_din.num      = r_inf_num;
      w_din.round    = r_inf_round;
      w_din.barrier  = 1'b0;
    end
  end

  nf_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BEAT_W)) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign ready_out         = sys_rst | (r_state == ST_IDLE);
  assign edge_rd_en        = w_rd;
  assign edge_rd_adr       = sys_rst ? '0 : r_addr;
  assign valid_out         = w_valid;
  assign neighbor_out      = w_valid ? w_head.neighbor : '0;
  assign sender_out        = w_valid ? w_head.sender   : '0;
  assign num_neighbors_out = w_valid ? w_head.num      : '0;
  assign round_out         = w_valid ? w_head.round    : '0;
  assign barrier_out       = w_valid & w_head.barrier;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_sender     <= '0;
      r_num        <= '0;
      r_count      <= '0;
      r_round      <= '0;
      r_addr       <= '0;
      r_inflight   <= 1'b0;
      r_inf_sender <= '0;
      r_inf_num    <= '0;
      r_inf_round  <= '0;
    end else begin
      r_inflight <= w_rd;
      // Each read carries its own command fields so the next command can be
      // accepted while the last word of this one is still in flight.
      if (w_rd) begin
        r_inf_sender <= r_sender;
        r_inf_num    <= r_num;
        r_inf_round  <= r_round;
        r_addr       <= r_addr + 1'b1;
        r_count      <= r_count - 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            if (barrier_in) begin
              r_round <= round_in;
              r_state <= ST_BARRIER;
            end else if (num_neighbors_in != 32'd0) begin
              r_sender <= sender_in;
              r_num    <= num_neighbors_in;
              r_count  <= num_neighbors_in;
              r_round  <= round_in;
              r_addr   <= start_idx_in;
              r_state  <= ST_FETCH;
            end
          end
        end
        ST_FETCH:   if (w_rd && r_count == 32'd1) r_state <= ST_IDLE;
        ST_BARRIER: if (w_bar_push) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_fetch.sv
// Directed and random command streams against a queue-based model of the
// expected beat and read-address sequences.
module tb_neighbor_fetch;

  localparam int AB    = 16;
  localparam int DEPTH = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [31:0]   sender_in = '0;
  logic [AB-1:0] start_idx_in = '0;
  logic [31:0]   num_neighbors_in = '0;
  logic [1:0]    round_in = '0;
  logic          barrier_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic          edge_rd_en;
  logic [AB-1:0] edge_rd_adr;
  logic [31:0]   edge_rd_dat = '0;
  logic [31:0]   neighbor_out, sender_out, num_neighbors_out;
  logic [1:0]    round_out;
  logic          barrier_out, valid_out;
  wire           ready_in;

  logic rnd_rdy = 1'b0, rnd_bit = 1'b0, rdy_set = 1'b1;
  assign ready_in = rnd_rdy ? rnd_bit : rdy_set;

  neighbor_fetch #(.EDGE_ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sender_in(sender_in),
    .start_idx_in(start_idx_in), .num_neighbors_in(num_neighbors_in),
    .round_in(round_in), .barrier_in(barrier_in), .valid_in(valid_in),
    .ready_out(ready_out), .edge_rd_en(edge_rd_en), .edge_rd_adr(edge_rd_adr),
    .edge_rd_dat(edge_rd_dat), .neighbor_out(neighbor_out), .sender_out(sender_out),
    .num_neighbors_out(num_neighbors_out), .round_out(round_out),
    .barrier_out(barrier_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 sys_clk = ~sys_clk;

  logic [31:0] mem [0:65535];

  always @(posedge sys_clk) begin
    edge_rd_dat <= edge_rd_en ? mem[edge_rd_adr] : $urandom;
    #1 rnd_bit = $urandom_range(0, 1);
  end

  typedef struct packed {
    logic [31:0] nb;
    logic [31:0] snd;
    logic [31:0] num;
    logic [1:0]  rnd;
    logic        bar;
  } exp_t;

  exp_t          expq[$];
  logic [AB-1:0] addrq[$];
  logic [AB-1:0] rdlog[$];
  int            bcyc[$];
  int ncmp = 0, nerr = 0;
  int cyc = 0, outst = 0, nbeats = 0, nnb = 0, nbar = 0;
  int acc_cyc = 0, fv_cyc = -1;
  bit fv_arm = 1'b0;
  logic [1:0] last_round = '0;
  logic       last_bar = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: everything seen at a falling edge takes effect on the next rising edge.
  always @(negedge sys_clk) begin
    exp_t          e;
    logic [AB-1:0] a;
    cyc++;
    if (sys_rst) begin
      expq.delete();
      addrq.delete();
      outst = 0;
    end else begin
      if (edge_rd_en) begin
        rdlog.push_back(edge_rd_adr);
        check("rd_expected", addrq.size() != 0, 1);
        if (addrq.size() != 0) begin
          a = addrq.pop_front();
          check("rd_adr", edge_rd_adr, a);
        end
        outst++;
      end
      if (valid_out && fv_arm) begin
        fv_cyc = cyc;
        fv_arm = 1'b0;
      end
      if (valid_out && ready_in) begin
        nbeats++;
        bcyc.push_back(cyc);
        last_round = round_out;
        last_bar   = barrier_out;
        if (barrier_out) nbar++; else begin nnb++; outst--; end
        check("beat_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("beat_barrier", barrier_out, e.bar);
          check("beat_neighbor", neighbor_out, e.nb);
          check("beat_round", round_out, e.rnd);
          if (!e.bar) begin
            check("beat_sender", sender_out, e.snd);
            check("beat_num", num_neighbors_out, e.num);
          end
        end
      end
      if (edge_rd_en) check("outstanding_le_depth", outst <= DEPTH, 1);
      if (valid_in && ready_out) begin
        acc_cyc = cyc;
        if (barrier_in) expq.push_back('{32'd0, 32'd0, 32'd0, round_in, 1'b1});
        else for (int i = 0; i < int'(num_neighbors_in); i++) begin
          a = start_idx_in + AB'(i);
          addrq.push_back(a);
          expq.push_back('{mem[a], sender_in, num_neighbors_in, round_in, 1'b0});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] snd, input logic [AB-1:0] st,
                      input logic [31:0] n, input logic [1:0] rnd, input logic bar);
    bit ok;
    ok = 1'b0;
    sender_in = snd; start_idx_in = st; num_neighbors_in = n;
    round_in = rnd; barrier_in = bar; valid_in = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge sys_clk);
      if (ready_out) ok = 1'b1;
    end
    check("accept_in_time", ok, 1);
    @(posedge sys_clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge sys_clk);
      if (expq.size() == 0 && ready_out && !valid_out && !edge_rd_en) done = 1'b1;
    end
    check("drain_in_time", done, 1);
    tick(1);
  endtask

  initial begin
    int nb0, nn0, nbar0, rds;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;

    // reset values
    tick(3);
    @(negedge sys_clk);
    check("rst_ready_out", ready_out, 1);
    check("rst_valid_out", valid_out, 0);
    check("rst_rd_en", edge_rd_en, 0);
    check("rst_rd_adr", edge_rd_adr, 0);
    check("rst_neighbor", neighbor_out, 0);
    check("rst_sender", sender_out, 0);
    check("rst_num", num_neighbors_out, 0);
    check("rst_round", round_out, 0);
    check("rst_barrier", barrier_out, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    tick(2);

    // three-neighbor list, back-to-back beats, two-edge latency
    mem[16'h10] = 32'd7; mem[16'h11] = 32'd8; mem[16'h12] = 32'd9;
    bcyc.delete();
    fv_arm = 1'b1;
    send(32'd5, 16'h10, 32'd3, 2'd0, 1'b0);
    drain(50);
    // accept edge follows falling edge n; data is pushed two rising edges
    // later and is first visible at falling edge n+3
    check("t1_latency", fv_cyc - acc_cyc, 3);
    check("t1_beats", bcyc.size(), 3);
    if (bcyc.size() == 3) begin
      check("t1_gap01", bcyc[1] - bcyc[0], 1);
      check("t1_gap12", bcyc[2] - bcyc[1], 1);
    end

    // empty list then barrier
    nn0 = nnb; nbar0 = nbar;
    send(32'd6, 16'h20, 32'd0, 2'd0, 1'b0);
    send(32'd0, 16'h0, 32'd0, 2'd1, 1'b1);
    drain(50);
    check("t2_no_neighbor", nnb - nn0, 0);
    check("t2_one_barrier", nbar - nbar0, 1);
    check("t2_round", last_round, 1);

    // stall mid-list
    nb0 = nbeats;
    send(32'd11, 16'h200, 32'd4, 2'd2, 1'b0);
    tick(1);
    rdy_set = 1'b0;
    tick(10);
    check("t3_stall_valid", valid_out, 1);
    check("t3_stall_no_read", edge_rd_en, 0);
    rdy_set = 1'b1;
    drain(50);
    check("t3_beats", nbeats - nb0, 4);

    // address wrap
    rdlog.delete();
    send(32'd12, 16'hFFFF, 32'd2, 2'd3, 1'b0);
    drain(50);
    check("t4_reads", rdlog.size(), 2);
    if (rdlog.size() == 2) begin
      check("t4_adr0", rdlog[0], 16'hFFFF);
      check("t4_adr1", rdlog[1], 16'h0000);
    end

    // barrier right behind a list
    nb0 = nbeats;
    send(32'd13, 16'h300, 32'd3, 2'd1, 1'b0);
    send(32'd0, 16'h0, 32'd0, 2'd2, 1'b1);
    drain(50);
    check("t5_beats", nbeats - nb0, 4);
    check("t5_last_is_barrier", last_bar, 1);
    check("t5_barrier_round", last_round, 2);

    // reset pulse after the second read of a five-neighbor list
    send(32'd14, 16'h400, 32'd5, 2'd0, 1'b0);
    rds = 0;
    for (int i = 0; i < 50 && rds < 2; i++) begin
      @(negedge sys_clk);
      if (edge_rd_en) rds++;
    end
    check("t6_two_reads", rds, 2);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("t6_rst_valid", valid_out, 0);
    check("t6_rst_ready", ready_out, 1);
    check("t6_rst_rd_en", edge_rd_en, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    nb0 = nbeats;
    @(negedge sys_clk);
    check("t6_post_valid", valid_out, 0);
    check("t6_post_ready", ready_out, 1);
    tick(10);
    check("t6_no_stale", nbeats - nb0, 0);

    // random commands with random backpressure
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [AB-1:0] st;
      st = ($urandom_range(0, 3) == 0) ? AB'(16'hFFFF - $urandom_range(0, 3)) : AB'($urandom);
      send($urandom, st, $urandom_range(0, 6), 2'($urandom), $urandom_range(0, 4) == 0);
      tick($urandom_range(0, 2));
    end
    drain(3000);
    rnd_rdy = 1'b0;
    rdy_set = 1'b1;
    tick(2);
    check("final_queue_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
